// File: rtl/prog_mem.sv
// Program memory: clears itself to FILL after reset, accepts a streamed program in LOAD,
// and serves single-cycle-latency instruction fetches in RUN.
module prog_mem #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    output logic              busy
);

    localparam int unsigned     IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
    localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DepthC  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   clr_ptr_q, clr_ptr_d;
    // One bit wider than the address so a full load reaches DEPTH without wrapping.
    logic [ADDR_W:0]   ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [IdxW-1:0]   waddr;
    logic [DATA_W-1:0] wdata;

    logic              fetch_ok;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_instr_q;
    logic              fetch_err_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ptr_d     = ptr_q;
        we        = 1'b0;
        waddr     = clr_ptr_q;
        wdata     = FILL;
        unique case (state_q)
            StClear: begin
                we = 1'b1;
                if (clr_ptr_q == LastIdx) begin
                    state_d   = StRun;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            StRun: begin
                if (load_start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q[IdxW-1:0];
                    wdata = ld_data;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LastPtr) begin
                        state_d = StRun;
                    end
                end
                if (load_end) begin
                    state_d = StRun;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ptr_q     <= ptr_d;
        end
    end

    // Storage is deliberately not reset; StClear does the initialisation.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign fetch_ok = (state_q == StRun) && fetch_req;
    assign in_range = ({1'b0, fetch_addr} < DepthC);

    always_comb begin
        rd_word = FILL;
        if (in_range) begin
            rd_word = mem[fetch_addr[IdxW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= FILL;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_ok;
            if (fetch_ok) begin
                fetch_instr_q <= rd_word;
                fetch_err_q   <= !in_range;
            end
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign ld_count    = ptr_q;
    assign ld_ready    = (state_q == StLoad);
    assign busy        = (state_q != StRun);

endmodule
